mc_ctrl_fsm: RTL and testbench

//  Multi-cycle MIPS control unit. Decodes opcode/funct and sequences each instruction through

---
 rtl/mc_ctrl_fsm_pkg.sv | 21 ++
 rtl/mc_ctrl_fsm_op_decode.sv | 35 +++
 rtl/mc_ctrl_fsm.sv | 100 ++++++++++
 tb/tb_mc_ctrl_fsm.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: state encodings, opcode/funct constants and datapath select codes.
package mc_ctrl_fsm_pkg;
  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
                         S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
                         S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
                         S_JAL    = 4'd12, S_RJR    = 4'd13;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_FN = 3'd2, ALU_AND = 3'd3,
                         ALU_OR = 3'd4, ALU_SLT = 3'd5, ALU_LUI = 3'd6;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_REGA = 2'd3;
  localparam logic [1:0] B_REG = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2, B_BR = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2;
  typedef enum logic [2:0] {C_ILL, C_MEM, C_R, C_JR, C_I, C_BR, C_J, C_JAL} cls_e;
  function automatic logic funct_ok(input logic [5:0] f);
    return f inside {6'h00, 6'h02, 6'h03, 6'h08, [6'h20:6'h27], 6'h2A, 6'h2B};
  endfunction
endpackage

// File: rtl/mc_ctrl_fsm_op_decode.sv
// mc_ctrl_fsm_op_decode: combinational op/funct to instruction class, immediate extension and ALU op.
module mc_ctrl_fsm_op_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic       is_sw,
  output logic       is_bne,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic       illegal
);
  always_comb begin
    cls = C_ILL;
    ext_op = 1'b0;
    alu_op = ALU_ADD;
    case (op)
      OP_LW, OP_SW:   cls = C_MEM;
      OP_R:           cls = !funct_ok(funct) ? C_ILL : (funct == FN_JR) ? C_JR : C_R;
      OP_ADDI:        begin cls = C_I; ext_op = 1'b1; end
      OP_SLTI:        begin cls = C_I; ext_op = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI:        begin cls = C_I; alu_op = ALU_AND; end
      OP_ORI:         begin cls = C_I; alu_op = ALU_OR; end
      OP_LUI:         begin cls = C_I; alu_op = ALU_LUI; end
      OP_BEQ, OP_BNE: cls = C_BR;
      OP_J:           cls = C_J;
      OP_JAL:         cls = C_JAL;
      default:        cls = C_ILL;
    endcase
  end
  assign is_sw   = op == OP_SW;
  assign is_bne  = op == OP_BNE;
  assign illegal = cls == C_ILL;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control unit sequencing FETCH/DECODE/EXEC/MEM/WB.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       illegal
);
  logic [3:0] state_q, state_d;
  logic       is_sw_q, is_sw_d, is_bne_q, is_bne_d, iext_q, iext_d;
  logic [2:0] ialu_q, ialu_d;
  cls_e       dec_cls;
  logic       dec_sw, dec_bne, dec_ext, dec_ill;
  logic [2:0] dec_alu;
  logic       rdy, pc_write, branch;
  mc_ctrl_fsm_op_decode u_dec (
    .op(op), .funct(funct), .cls(dec_cls), .is_sw(dec_sw), .is_bne(dec_bne),
    .ext_op(dec_ext), .alu_op(dec_alu), .illegal(dec_ill)
  );
  assign rdy = mem_ready | ~MEM_WAIT_EN;
  // IR is only guaranteed stable in DECODE, so instruction attributes needed later are latched there
  always_comb begin
    {is_sw_d, is_bne_d, iext_d, ialu_d} = (state_q == S_DECODE) ?
      {dec_sw, dec_bne, dec_ext, dec_alu} : {is_sw_q, is_bne_q, iext_q, ialu_q};
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE:
        case (dec_cls)
          C_MEM:   state_d = S_MEMADR;
          C_R:     state_d = S_EXEC;
          C_JR:    state_d = S_RJR;
          C_I:     state_d = S_IEXEC;
          C_BR:    state_d = S_BRANCH;
          C_J:     state_d = S_JUMP;
          C_JAL:   state_d = S_JAL;
          default: state_d = S_FETCH;
        endcase
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      {is_sw_q, is_bne_q, iext_q, ialu_q} <= '0;
    end else begin
      state_q <= state_d;
      {is_sw_q, is_bne_q, iext_q, ialu_q} <= {is_sw_d, is_bne_d, iext_d, ialu_d};
    end
  end
  // Every output defaults to zero so reset forces all enables and selects low
  always_comb begin
    {pc_src, iord, ir_write, mem_write, alusrca, alusrcb, ext_op, alu_op} = '0;
    {reg_dst, mem_to_reg, reg_write, illegal, pc_write, branch} = '0;
    if (!rst)
      case (state_q)
        S_FETCH:  begin alusrcb = B_FOUR; ir_write = rdy; pc_write = rdy; end
        S_DECODE: begin alusrcb = B_BR; illegal = dec_ill; end
        S_MEMADR: begin alusrca = 1'b1; alusrcb = B_IMM; ext_op = 1'b1; end
        S_MEMRD:  iord = 1'b1;
        S_MEMWB:  begin mem_to_reg = WB_MEM; reg_write = 1'b1; end
        S_MEMWR:  begin iord = 1'b1; mem_write = 1'b1; end
        S_EXEC:   begin alusrca = 1'b1; alu_op = ALU_FN; end
        S_ALUWB:  begin reg_dst = DST_RD; reg_write = 1'b1; end
        S_IEXEC:  begin alusrca = 1'b1; alusrcb = B_IMM; ext_op = iext_q; alu_op = ialu_q; end
        S_IWB:    reg_write = 1'b1;
        S_BRANCH: begin alusrca = 1'b1; alu_op = ALU_SUB; pc_src = PC_ALUOUT; branch = 1'b1; end
        S_JUMP:   begin pc_src = PC_JUMP; pc_write = 1'b1; end
        S_JAL:    begin pc_src = PC_JUMP; pc_write = 1'b1; reg_dst = DST_RA; mem_to_reg = WB_PC; reg_write = 1'b1; end
        S_RJR:    begin pc_src = PC_REGA; pc_write = 1'b1; end
        default:  pc_write = 1'b0;
      endcase
  end
  assign pc_en = pc_write | (branch & (zero ^ is_bne_q));
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized instruction stream against a per-instruction cycle model with a scoreboard.
module tb_mc_ctrl_fsm;
  logic       clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       pc_en, iord, ir_write, mem_write, alusrca, ext_op, reg_write, illegal;
  logic [1:0] pc_src, alusrcb, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  typedef logic [18:0] vec_t;
  vec_t  exp_q[$];
  string tag_q[$];
  int    total = 0, bad = 0;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .ir_write(ir_write), .mem_write(mem_write),
    .alusrca(alusrca), .alusrcb(alusrcb), .ext_op(ext_op), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic pe, input logic [1:0] ps, input logic io, ir, mw, asa,
                              input logic [1:0] asb, input logic ex, input logic [2:0] al,
                              input logic [1:0] rd, m2r, input logic rw, il);
    return {pe, ps, io, ir, mw, asa, asb, ex, al, rd, m2r, rw, il};
  endfunction

  function automatic logic legal(input logic [5:0] o, f);
    if (o == 6'h00) return f inside {6'h00, 6'h02, 6'h03, 6'h08, [6'h20:6'h27], 6'h2A, 6'h2B};
    return o inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] o);
    case (o)
      6'h0A:   return 3'd5;
      6'h0C:   return 3'd3;
      6'h0D:   return 3'd4;
      6'h0F:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  always @(negedge clk) begin
    vec_t  e, act;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {pc_en, pc_src, iord, ir_write, mem_write, alusrca, alusrcb, ext_op, alu_op,
             reg_dst, mem_to_reg, reg_write, illegal};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got=%05h want=%05h (op=%02h funct=%02h)", t, act, e, op, funct);
      end
    end
  end

  task automatic cyc(input logic r, rdy, z, input logic [5:0] o, f, input vec_t e, input string t);
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; zero = z; op = o; funct = f;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_fetch(input int fw);
    repeat (fw) cyc('0, '0, rb(), r6(), r6(), mk('0, 2'd0, '0, '0, '0, '0, 2'd1, '0, 3'd0, 2'd0, 2'd0, '0, '0), "fetch_wait");
    cyc('0, '1, rb(), r6(), r6(), mk('1, 2'd0, '0, '1, '0, '0, 2'd1, '0, 3'd0, 2'd0, 2'd0, '0, '0), "fetch");
  endtask

  // One instruction: opcode/funct are only presented during DECODE, garbage elsewhere
  task automatic run(input logic [5:0] o, f, input int fw, mw, input logic zb);
    logic ill, sw;
    vec_t mv;
    ill = !legal(o, f);
    sw = (o == 6'h2B);
    do_fetch(fw);
    cyc('0, rb(), rb(), o, f, mk('0, 2'd0, '0, '0, '0, '0, 2'd3, '0, 3'd0, 2'd0, 2'd0, '0, ill), "decode");
    if (ill) return;
    if (o == 6'h23 || sw) begin
      cyc('0, rb(), rb(), r6(), r6(), mk('0, 2'd0, '0, '0, '0, '1, 2'd2, '1, 3'd0, 2'd0, 2'd0, '0, '0), "memadr");
      mv = mk('0, 2'd0, '1, '0, sw, '0, 2'd0, '0, 3'd0, 2'd0, 2'd0, '0, '0);
      repeat (mw) cyc('0, '0, rb(), r6(), r6(), mv, "mem_wait");
      cyc('0, '1, rb(), r6(), r6(), mv, "mem_done");
      if (!sw) cyc('0, rb(), rb(), r6(), r6(), mk('0, 2'd0, '0, '0, '0, '0, 2'd0, '0, 3'd0, 2'd0, 2'd1, '1, '0), "memwb");
    end else if (o == 6'h00 && f == 6'h08) begin
      cyc('0, rb(), rb(), r6(), r6(), mk('1, 2'd3, '0, '0, '0, '0, 2'd0, '0, 3'd0, 2'd0, 2'd0, '0, '0), "jr");
    end else if (o == 6'h00) begin
      cyc('0, rb(), rb(), r6(), r6(), mk('0, 2'd0, '0, '0, '0, '1, 2'd0, '0, 3'd2, 2'd0, 2'd0, '0, '0), "exec");
      cyc('0, rb(), rb(), r6(), r6(), mk('0, 2'd0, '0, '0, '0, '0, 2'd0, '0, 3'd0, 2'd1, 2'd0, '1, '0), "aluwb");
    end else if (o == 6'h04 || o == 6'h05) begin
      cyc('0, rb(), zb, r6(), r6(), mk((o == 6'h05) ? !zb : zb, 2'd1, '0, '0, '0, '1, 2'd0, '0, 3'd1, 2'd0, 2'd0, '0, '0), "branch");
    end else if (o == 6'h02) begin
      cyc('0, rb(), rb(), r6(), r6(), mk('1, 2'd2, '0, '0, '0, '0, 2'd0, '0, 3'd0, 2'd0, 2'd0, '0, '0), "jump");
    end else if (o == 6'h03) begin
      cyc('0, rb(), rb(), r6(), r6(), mk('1, 2'd2, '0, '0, '0, '0, 2'd0, '0, 3'd0, 2'd2, 2'd2, '1, '0), "jal");
    end else begin
      cyc('0, rb(), rb(), r6(), r6(), mk('0, 2'd0, '0, '0, '0, '1, 2'd2, o == 6'h08 || o == 6'h0A, imm_alu(o), 2'd0, 2'd0, '0, '0), "iexec");
      cyc('0, rb(), rb(), r6(), r6(), mk('0, 2'd0, '0, '0, '0, '0, 2'd0, '0, 3'd0, 2'd0, 2'd0, '1, '0), "iwb");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [12];
    logic [5:0] fns [14];
    logic [5:0] o, f;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    repeat (2) cyc('1, rb(), rb(), r6(), r6(), '0, "reset");
    run(6'h23, r6(), 0, 0, '0);
    run(6'h2B, r6(), 0, 3, '0);
    run(6'h04, r6(), 0, 0, '1);
    run(6'h05, r6(), 0, 0, '1);
    run(6'h05, r6(), 0, 0, '0);
    run(6'h03, r6(), 0, 0, '0);
    run(6'h3F, r6(), 0, 0, '0);
    run(6'h00, 6'h01, 0, 0, '0);
    run(6'h00, 6'h08, 1, 0, '0);
    // reset in the middle of a stalled store
    do_fetch(0);
    cyc('0, rb(), rb(), 6'h2B, r6(), mk('0, 2'd0, '0, '0, '0, '0, 2'd3, '0, 3'd0, 2'd0, 2'd0, '0, '0), "decode_sw");
    cyc('0, rb(), rb(), r6(), r6(), mk('0, 2'd0, '0, '0, '0, '1, 2'd2, '1, 3'd0, 2'd0, 2'd0, '0, '0), "memadr_sw");
    cyc('0, '0, rb(), r6(), r6(), mk('0, 2'd0, '1, '0, '1, '0, 2'd0, '0, 3'd0, 2'd0, 2'd0, '0, '0), "memwr_pre_rst");
    cyc('1, '0, rb(), r6(), r6(), '0, "rst_in_memwr");
    cyc('1, '1, rb(), r6(), r6(), '0, "rst_in_memwr2");
    run(6'h08, r6(), 1, 0, '0);
    for (int i = 0; i < 200; i++) begin
      o = ($urandom_range(0, 9) == 0) ? r6() : ops[$urandom_range(0, 11)];
      f = ($urandom_range(0, 7) == 0) ? r6() : fns[$urandom_range(0, 13)];
      run(o, f, $urandom_range(0, 2), $urandom_range(0, 2), rb());
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
